// File: rtl/tc_pkg.sv
// Shared definitions for the TinyComp input-port arbiter.
//   tc_arb_state_e : slot state (empty / full)
//   TC_DATA_W      : processor input word width
//   TC_TAG_W       : width of the source tag carried in InData when tagging is on
//   TC_TAG_LSB     : bit position of the tag inside InData
package tc_pkg;

   typedef enum logic [0:0] {
      TC_ARB_EMPTY = 1'b0,
      TC_ARB_FULL  = 1'b1
   } tc_arb_state_e;

   localparam int TC_DATA_W  = 32;
   localparam int TC_TAG_W   = 4;
   localparam int TC_TAG_LSB = 28;

endpackage

// File: rtl/tc_in_arbiter_if.sv
// Producer/processor-side bundle of the input-port arbiter.
//   src_valid/src_data/src_ready : per-producer valid/ready handshakes
//   InData/InRdy/InStrobe        : TinyComp input port
//   Flush                        : drop the slot word
//   last_src                     : producer index of the slot word
//   underrun                     : sticky "Input executed while empty"
// slave  = arbiter side, master = producers + processor side.
interface tc_in_arbiter_if #(
   parameter int N_SRC  = 4,
   parameter int DATA_W = 32
);
   logic [N_SRC-1:0]        src_valid;
   logic [N_SRC*DATA_W-1:0] src_data;
   logic [N_SRC-1:0]        src_ready;
   logic [31:0]             InData;
   logic                    InRdy;
   logic                    InStrobe;
   logic                    Flush;
   logic [3:0]              last_src;
   logic                    underrun;

   modport slave (
      input  src_valid, src_data, InStrobe, Flush,
      output src_ready, InData, InRdy, last_src, underrun
   );

   modport master (
      output src_valid, src_data, InStrobe, Flush,
      input  src_ready, InData, InRdy, last_src, underrun
   );
endinterface

// File: rtl/tc_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : index of the last winner; search starts at ptr+1 and wraps
//   gnt : one-hot grant (zero when no request)
//   idx : encoded index of the granted request
//   any : at least one request present
module tc_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   always_comb begin
      int j;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = 0;
      for (int k = 1; k <= N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/tc_in_arbiter.sv
// Round-robin arbiter sharing the TinyComp input port among N_SRC producers
// through a one-entry slot. Clocked on Ph0 with synchronous active-high Reset.
// Ports:
//   Ph0   : clock (same phase that advances the PC)
//   Reset : synchronous, active-high
//   bus   : tc_in_arbiter_if.slave (handshakes, input port, Flush, status)
// Build option: TC_INARB_TAG_EN places last_src in InData[31:28] and keeps
// payload bits [27:0]; without it InData carries the full payload.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_EMPTY  | slot invalid; round-robin grant offered to producers
// ST_FULL   | slot valid; waiting for InStrobe (consume) or Flush
module tc_in_arbiter
   import tc_pkg::*;
#(
   parameter int N_SRC  = 4,
   parameter int DATA_W = 32
) (
   input logic              Ph0,
   input logic              Reset,
   tc_in_arbiter_if.slave   bus
);

   localparam int IW = $clog2(N_SRC);

   localparam logic [0:0] ST_EMPTY = TC_ARB_EMPTY;
   localparam logic [0:0] ST_FULL  = TC_ARB_FULL;

   logic [0:0]           state;
   logic [TC_DATA_W-1:0] slot;
   logic [IW-1:0]        rr_ptr;
   logic [3:0]           last_src;
   logic                 underrun;

   logic [N_SRC-1:0]     pick_gnt;
   logic [IW-1:0]        pick_idx;
   logic                 pick_any;
   logic                 grant_en;
   logic                 xfer;
   logic [TC_DATA_W-1:0] slot_nxt;

   tc_rr_pick #(.N(N_SRC), .IW(IW)) u_pick (
      .req (bus.src_valid),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Grant only while empty; Flush and Reset both suppress it for the cycle.
   assign grant_en = (state == ST_EMPTY) && !bus.Flush && !Reset;
   assign xfer     = grant_en && pick_any;

   // The slot stores the word already formatted for InData, so the tag path
   // needs no extra register.
`ifdef TC_INARB_TAG_EN
   assign slot_nxt = {TC_TAG_W'(pick_idx),
                      bus.src_data[int'(pick_idx)*DATA_W +: TC_TAG_LSB]};
`else
   assign slot_nxt = bus.src_data[int'(pick_idx)*DATA_W +: TC_DATA_W];
`endif

   always_ff @(posedge Ph0) begin
      if (Reset) begin
         state    <= ST_EMPTY;
         slot     <= '0;
         rr_ptr   <= IW'(N_SRC - 1);
         last_src <= '0;
         underrun <= 1'b0;
      end else begin
         if (bus.InStrobe && (state == ST_EMPTY))
            underrun <= 1'b1;
         case (state)
            ST_EMPTY: begin
               if (xfer) begin
                  slot     <= slot_nxt;
                  last_src <= 4'(pick_idx);
                  rr_ptr   <= pick_idx;
                  state    <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (bus.Flush || bus.InStrobe)
                  state <= ST_EMPTY;
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

   assign bus.src_ready = grant_en ? pick_gnt : '0;
   assign bus.InRdy     = (state == ST_FULL);
   // Slot register keeps its old word after consume; hide it when invalid.
   assign bus.InData    = (state == ST_FULL) ? slot : '0;
   assign bus.last_src  = last_src;
   assign bus.underrun  = underrun;

endmodule

// File: tb/tb_tc_in_arbiter.sv
module tb_tc_in_arbiter;
   import tc_pkg::*;

   localparam int N = 4;

   logic Ph0 = 1'b0;
   logic Reset;

   tc_in_arbiter_if #(.N_SRC(N), .DATA_W(32)) bus ();

   tc_in_arbiter #(.N_SRC(N), .DATA_W(32)) dut (
      .Ph0   (Ph0),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Ph0 = ~Ph0;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: slot contents, last winner, sticky underrun.
   bit          m_full;
   bit          m_under;
   int          m_src;
   int          m_last;
   logic [31:0] m_word;

   // Producers: each holds a pending word until it is taken.
   bit          pend[N];
   logic [31:0] pdata[N];
   int          grants[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   function automatic logic [31:0] fmt(input logic [31:0] w);
`ifdef TC_INARB_TAG_EN
      return {4'(m_src), w[27:0]};
`else
      return w;
`endif
   endfunction

   task automatic model_reset();
      m_full  = 0;
      m_under = 0;
      m_src   = 0;
      m_last  = N - 1;
      m_word  = '0;
   endtask

   // One Ph0 cycle: drive after negedge, check combinational/registered
   // outputs against the model, then advance the model at the posedge.
   task automatic step(input bit rst, input bit strb, input bit fl);
      logic [N-1:0] v;
      logic [N-1:0] exp_rdy;
      int win;
      @(negedge Ph0);
      v = '0;
      for (int i = 0; i < N; i++) begin
         v[i] = pend[i];
         bus.src_data[32*i +: 32] = pdata[i];
      end
      bus.src_valid = v;
      bus.InStrobe  = strb;
      bus.Flush     = fl;
      Reset         = rst;
      #1;
      win = -1;
      if (!rst && !m_full && !fl)
         for (int k = 1; k <= N; k++)
            if (win < 0 && pend[(m_last + k) % N]) win = (m_last + k) % N;
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      check("src_ready", 32'(bus.src_ready), 32'(exp_rdy));
      check("InRdy",     32'(bus.InRdy),     32'(m_full));
      check("InData",    bus.InData,         m_full ? fmt(m_word) : 32'h0);
      check("last_src",  32'(bus.last_src),  32'(m_src));
      check("underrun",  32'(bus.underrun),  32'(m_under));
      @(posedge Ph0);
      if (rst) begin
         model_reset();
      end else begin
         if (strb && !m_full) m_under = 1;
         if (win >= 0) begin
            m_full    = 1;
            m_word    = pdata[win];
            m_src     = win;
            m_last    = win;
            pend[win] = 0;
            grants.push_back(win);
         end else if (m_full && (fl || strb)) begin
            m_full = 0;
         end
      end
   endtask

   task automatic refill_all();
      for (int i = 0; i < N; i++)
         if (!pend[i]) begin
            pend[i]  = 1;
            pdata[i] = $urandom;
         end
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) pend[i] = 0;
   endtask

   initial begin
      logic [31:0] tag_exp;
      bus.src_valid = '0;
      bus.src_data  = '0;
      bus.InStrobe  = 1'b0;
      bus.Flush     = 1'b0;
      Reset         = 1'b1;
      for (int i = 0; i < N; i++) begin
         pend[i]  = 0;
         pdata[i] = '0;
      end
      repeat (2) @(posedge Ph0);
      model_reset();

      // Reset values and a single word from producer 0.
      step(0, 0, 0);
      pend[0]  = 1;
      pdata[0] = 32'hDEADBEEF;
      step(0, 0, 0);
      step(0, 0, 0);
      check("t1_InData", bus.InData, fmt(32'hDEADBEEF));
      step(0, 1, 0);
      step(0, 0, 0);

      // Full contention, consume every other cycle: order 0,1,2,3,0.
      step(1, 0, 0);
      grants.delete();
      for (int c = 0; c < 10; c++) begin
         refill_all();
         step(0, (c % 2) == 1, 0);
      end
      check("rr_count", 32'(grants.size()), 32'd5);
      for (int g = 0; g < 5; g++)
         if (g < grants.size()) check("rr_order", 32'(grants[g]), 32'(g % N));

      // Underrun: Input with empty slot, flag sticks.
      clear_all();
      step(0, 1, 0);
      for (int c = 0; c < 4; c++) step(0, 0, 0);
      check("underrun_sticky", 32'(bus.underrun), 32'd1);

      // Flush and InStrobe together on a word from producer 2.
      step(1, 0, 0);
      pend[2]  = 1;
      pdata[2] = $urandom;
      step(0, 0, 0);
      pend[0] = 1; pend[1] = 1; pend[3] = 1;
      step(0, 1, 1);
      grants.delete();
      step(0, 0, 0);
      check("flush_next_grant", grants.size() > 0 ? 32'(grants[0]) : 32'hFFFF_FFFF, 32'd3);

      // Producer 3 sends all ones.
      step(1, 0, 0);
      clear_all();
      pend[3]  = 1;
      pdata[3] = 32'hFFFFFFFF;
      step(0, 0, 0);
      step(0, 0, 0);
`ifdef TC_INARB_TAG_EN
      tag_exp = 32'h3FFFFFFF;
`else
      tag_exp = 32'hFFFFFFFF;
`endif
      check("tag_data", bus.InData, tag_exp);

      // Reset while FULL with every producer requesting.
      refill_all();
      step(1, 0, 0);
      grants.delete();
      step(0, 0, 0);
      check("post_reset_first", grants.size() > 0 ? 32'(grants[0]) : 32'hFFFF_FFFF, 32'd0);

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom_range(2) == 0)) begin
               pend[i]  = 1;
               pdata[i] = $urandom;
            end else if (pend[i] && ($urandom_range(15) == 0)) begin
               pend[i] = 0;
            end
         end
         step($urandom_range(49) == 0, $urandom_range(2) == 0, $urandom_range(7) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/tc_in_arbiter.md
# tc_in_arbiter

Round-robin input-port arbiter that shares the TinyComp processor's single input port (InData/InRdy/InStrobe) among N_SRC independent producers. It accepts one word at a time from the producers through valid/ready handshakes and holds it in a one-entry slot. The processor tests the slot with its InRdy skip and consumes it with an Input instruction. The block sits between the I/O producers and the processor core. It is clocked on the processor's Ph0, the same edge that advances the PC.

## Interface
Parameters:
- N_SRC, 4, number of producers (2..16)
- DATA_W, 32, payload width; fixed at 32 to match InData

Ports:
- Ph0  input  1  clock; same buffered phase that updates the PC
- Reset  input  1  reset, synchronous, active-high
- src_valid  input  N_SRC  per-producer word available
- src_data  input  N_SRC*DATA_W  per-producer payload; producer i occupies bits [32*i+31 : 32*i]
- src_ready  output  N_SRC  one-hot grant; a transfer occurs when src_valid[i] & src_ready[i] at posedge Ph0
- InData  output  32  slot contents to the processor
- InRdy  output  1  slot holds a valid word
- InStrobe  input  1  processor is executing an Input instruction this cycle
- Flush  input  1  discard the slot contents
- last_src  output  4  index of the producer whose word is currently in the slot
- underrun  output  1  sticky flag: InStrobe was seen while InRdy=0

## Operation
- FSM states:
  - EMPTY: slot invalid.
  - FULL: slot valid.
- EMPTY:
  - src_ready is the one-hot output of the round-robin pick over src_valid, searching from rr_ptr+1 upward with wrap.
  - src_ready is all-zero when no src_valid is set.
  - On a transfer: slot <= src_data[i], last_src <= i, rr_ptr <= i, go to FULL.
- FULL:
  - src_ready = 0.
  - InRdy = 1, InData = slot.
  - InStrobe=1 at posedge Ph0: go to EMPTY (word consumed).
  - Flush=1: go to EMPTY, word dropped. Flush overrides InStrobe when both are set.
- InStrobe=1 while EMPTY: no state change, underrun <= 1. Any producer transfer in that same cycle still proceeds.
- Flush in EMPTY blocks the grant: src_ready = 0 that cycle.
- The slot's data register does not clear on consume; InData is gated to 0 whenever InRdy=0.
- rr_ptr advances only on a transfer; the arbitration is fair under constant contention.

## Timing
- Reset values:
  - state=EMPTY, InRdy=0, InData=0.
  - src_ready=0 during the reset cycle.
  - rr_ptr=N_SRC-1, so producer 0 wins first.
  - last_src=0, underrun=0.
- Latency:
  - src_valid asserted in EMPTY gives src_ready in the same cycle (combinational).
  - InRdy=1 on the cycle after the transfer.
- Minimum turnaround:
  - The consume edge moves the slot to EMPTY.
  - The next grant happens in the following cycle.
  - Result: one word every 2 Ph0 cycles.
- A producer must hold src_valid and src_data stable until it sees ready. Deasserting src_valid before the grant is legal, and no transfer occurs.
- Reset mid-operation: the slot word is discarded, any pending grant is cancelled, and underrun clears.

## Configuration
- TC_INARB_TAG_EN defined:
  - InData[31:28] = last_src (zero-extended).
  - InData[27:0] = payload[27:0].
  - Payload bits [31:28] are dropped.
- TC_INARB_TAG_EN undefined: InData = full 32-bit payload, and last_src is still driven.

## Structure
- Shared package tc_pkg holds:
  - the state enum (TC_ARB_EMPTY, TC_ARB_FULL);
  - TC_DATA_W=32;
  - TC_TAG_W=4;
  - TC_TAG_LSB=28.
- Sub-module tc_rr_pick is a parameterized combinational round-robin picker.
  - Inputs: req[N], ptr.
  - Outputs: one-hot gnt, encoded idx, any.

## Test plan
- Reset, then src_valid=4'b0001 with src_data[0]=32'hDEADBEEF:
  - src_ready=0001 in the same cycle;
  - InRdy=1 and InData=DEADBEEF next cycle;
  - InStrobe for one cycle, then InRdy=0.
- All four producers valid continuously, InStrobe pulsed every other cycle → grant order 0,1,2,3,0, with one word every 2 cycles.
- InStrobe with the slot empty → underrun=1 and it stays set until Reset; the state is unchanged.
- Slot FULL from producer 2, then Flush and InStrobe together → InRdy=0 next cycle, no consume counted, next grant goes to producer 3.
- TC_INARB_TAG_EN defined, producer 3 sends 32'hFFFFFFFF → InData=32'h3FFFFFFF.
- Reset asserted while FULL with src_valid=1111 → InRdy=0, src_ready=0 during reset, and producer 0 is granted first after release.
